// File: rtl/beep_seq.sv
// Buzzer tone sequencer: manual tones from five active-low keys, or playback
// of a fixed 8-note melody with a silent gap after every note.
module beep_seq #(
    parameter int unsigned TONE_UNIT = 100_000,
    parameter int unsigned NOTE_LEN  = 25_000_000,
    parameter int unsigned GAP_LEN   = 2_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] key,
    input  logic       start,
    input  logic       stop,
    output logic       beep,
    output logic [4:0] led,
    output logic       busy,
    output logic [2:0] note_idx
);

    typedef enum logic [1:0] {IDLE, MANUAL, PLAY, GAP} state_t;

    state_t      state_r, state_s;
    logic [4:0]  key_s1_r, key_s2_r;
    logic [2:0]  code_r, code_s, sel_s, idx_s;
    logic [31:0] dur_r, tone_r, half_s;
    logic        restart_s;

    function automatic logic [2:0] rom_code(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_code = 3'd1;
            3'd1:    rom_code = 3'd2;
            3'd2:    rom_code = 3'd3;
            3'd3:    rom_code = 3'd4;
            3'd4:    rom_code = 3'd5;
            3'd5:    rom_code = 3'd0;
            3'd6:    rom_code = 3'd3;
            3'd7:    rom_code = 3'd1;
            default: rom_code = 3'd0;
        endcase
    endfunction

    function automatic logic [4:0] thermo(input logic [2:0] code);
        case (code)
            3'd1:    thermo = 5'b00001;
            3'd2:    thermo = 5'b00011;
            3'd3:    thermo = 5'b00111;
            3'd4:    thermo = 5'b01111;
            3'd5:    thermo = 5'b11111;
            default: thermo = 5'b00000;
        endcase
    endfunction

    // Lowest-numbered pressed key wins; 0 means no key pressed.
    always_comb begin
        sel_s = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (!key_s2_r[i]) begin
                sel_s = 3'(i + 1);
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Next-state and next-note selection; stop outranks keys, keys outrank start.
    always_comb begin
        state_s = state_r;
        idx_s   = note_idx;
        case (state_r)
            IDLE: begin
                idx_s = 3'd0;
                if (stop) begin
                    state_s = IDLE;
                end else if (sel_s != 3'd0) begin
                    state_s = MANUAL;
                end else if (start) begin
                    state_s = PLAY;
                end else begin
                    state_s = IDLE;
                end
            end
            MANUAL: begin
                idx_s = 3'd0;
                if (sel_s == 3'd0) begin
                    state_s = IDLE;
                end else begin
                    state_s = MANUAL;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_s = IDLE;
                    idx_s   = 3'd0;
                end else if (sel_s != 3'd0) begin
                    state_s = MANUAL;
                    idx_s   = 3'd0;
                end else if (dur_r == 32'(NOTE_LEN - 1)) begin
                    state_s = GAP;
                end else begin
                    state_s = PLAY;
                end
            end
            GAP: begin
                if (stop) begin
                    state_s = IDLE;
                    idx_s   = 3'd0;
                end else if (sel_s != 3'd0) begin
                    state_s = MANUAL;
                    idx_s   = 3'd0;
                end else if (dur_r == 32'(GAP_LEN - 1)) begin
                    if (note_idx == 3'd7) begin
                        state_s = IDLE;
                        idx_s   = 3'd0;
                    end else begin
                        state_s = PLAY;
                        idx_s   = note_idx + 3'd1;
                    end
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = 3'd0;
            end
        endcase
    end

    // Tone code for the state about to be entered; silent states give 0.
    always_comb begin
        case (state_s)
            MANUAL:  code_s = sel_s;
            PLAY:    code_s = rom_code(idx_s);
            default: code_s = 3'd0;
        endcase
        half_s    = 32'(code_r) * 32'(TONE_UNIT);
        restart_s = (state_s != state_r) || (code_s != code_r);
    end

    // Synchronizer, state, duration/tone counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1_r <= 5'h1f;
            key_s2_r <= 5'h1f;
            state_r  <= IDLE;
            code_r   <= 3'd0;
            dur_r    <= 32'd0;
            tone_r   <= 32'd0;
            beep     <= 1'b0;
            led      <= 5'd0;
            busy     <= 1'b0;
            note_idx <= 3'd0;
        end else begin
            key_s1_r <= key;
            key_s2_r <= key_s1_r;
            state_r  <= state_s;
            code_r   <= code_s;
            led      <= thermo(code_s);
            busy     <= (state_s == PLAY) || (state_s == GAP);
            note_idx <= idx_s;
            if ((state_s == state_r) && ((state_s == PLAY) || (state_s == GAP))) begin
                dur_r <= dur_r + 32'd1;
            end else begin
                dur_r <= 32'd0;
            end
            if (restart_s || (code_s == 3'd0)) begin
                tone_r <= 32'd0;
                beep   <= 1'b0;
            end else if (tone_r == half_s - 32'd1) begin
                tone_r <= 32'd0;
                beep   <= ~beep;
            end else begin
                tone_r <= tone_r + 32'd1;
                beep   <= beep;
            end
        end
    end

endmodule

// File: tb/tb_beep_seq.sv
// Scoreboard bench for beep_seq: a melody-time reference model predicts outputs
// each cycle, a monitor compares them after every rising edge.
module tb_beep_seq;

    localparam int TU  = 4;
    localparam int NL  = 40;
    localparam int GL  = 8;
    localparam int NTL = NL + GL;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] key = 5'h1f;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       beep;
    logic [4:0] led;
    logic       busy;
    logic [2:0] note_idx;

    typedef struct packed {
        logic       beep;
        logic [4:0] led;
        logic       busy;
        logic [2:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // model state: mode 0 idle, 1 manual, 2 melody
    int         m_mode = 0;
    int         m_t = 0;
    int         m_code = 0;
    int         m_el = 0;
    logic [4:0] m_s1 = 5'h1f;
    logic [4:0] m_s2 = 5'h1f;
    int         melody [8] = '{1, 2, 3, 4, 5, 0, 3, 1};

    beep_seq #(.TONE_UNIT(TU), .NOTE_LEN(NL), .GAP_LEN(GL)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .start(start), .stop(stop),
        .beep(beep), .led(led), .busy(busy), .note_idx(note_idx)
    );

    always #5 clk = ~clk;

    function automatic exp_t predict();
        exp_t e;
        int   code;
        int   pos;
        e = '0;
        if (m_mode == 1) begin
            e.led  = 5'((1 << m_code) - 1);
            e.beep = 1'(((m_el / (m_code * TU)) % 2));
        end else if (m_mode == 2) begin
            pos   = m_t % NTL;
            e.idx = 3'(m_t / NTL);
            e.busy = 1'b1;
            code  = (pos < NL) ? melody[m_t / NTL] : 0;
            e.led = 5'((1 << code) - 1);
            e.beep = (code == 0) ? 1'b0 : 1'(((pos / (code * TU)) % 2));
        end
        return e;
    endfunction

    task automatic step(input logic [4:0] k, input logic st, input logic sp, input logic rn);
        int sel;
        @(negedge clk);
        key = k; start = st; stop = sp; rst_n = rn;
        sel = 0;
        for (int i = 4; i >= 0; i--) if (!m_s2[i]) sel = i + 1;
        if (!rn) begin
            m_mode = 0; m_t = 0; m_s1 = 5'h1f; m_s2 = 5'h1f;
        end else begin
            case (m_mode)
                0: if (!sp) begin
                    if (sel != 0) begin m_mode = 1; m_code = sel; m_el = 0; end
                    else if (st) begin m_mode = 2; m_t = 0; end
                end
                1: if (sel == 0) m_mode = 0;
                   else if (sel != m_code) begin m_code = sel; m_el = 0; end
                   else m_el++;
                2: if (sp) m_mode = 0;
                   else if (sel != 0) begin m_mode = 1; m_code = sel; m_el = 0; end
                   else begin m_t++; if (m_t == 8 * NTL) m_mode = 0; end
                default: m_mode = 0;
            endcase
            m_s2 = m_s1;
            m_s1 = k;
        end
        exp_q.push_back(predict());
    endtask

    task automatic idle(input int n);
        repeat (n) step(5'h1f, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic hold(input logic [4:0] k, input int n);
        repeat (n) step(k, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: compare every predicted cycle just after the rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 4;
            if (beep !== e.beep) begin
                errors++;
                $display("FAIL beep t=%0t got=%b want=%b", $time, beep, e.beep);
            end
            if (led !== e.led) begin
                errors++;
                $display("FAIL led t=%0t got=%b want=%b", $time, led, e.led);
            end
            if (busy !== e.busy) begin
                errors++;
                $display("FAIL busy t=%0t got=%b want=%b", $time, busy, e.busy);
            end
            if (note_idx !== e.idx) begin
                errors++;
                $display("FAIL note_idx t=%0t got=%0d want=%0d", $time, note_idx, e.idx);
            end
        end
    end

    initial begin
        int len, kind, evt;
        logic [4:0] kp;
        logic st0;
        repeat (3) step(5'h1f, 1'b0, 1'b0, 1'b0);
        idle(100);
        hold(5'b11110, 30); idle(10);
        hold(5'b11010, 30); hold(5'b11011, 40); idle(10);
        step(5'h1f, 1'b1, 1'b0, 1'b1); idle(8 * NTL + 16);
        step(5'h1f, 1'b1, 1'b0, 1'b1); idle(2 * NTL + 10);
        step(5'h1f, 1'b0, 1'b1, 1'b1); idle(10);
        step(5'h1f, 1'b1, 1'b1, 1'b1); idle(20);
        step(5'h1f, 1'b1, 1'b0, 1'b1); idle(3 * NTL + 12);
        hold(5'b01111, 20); idle(10);
        step(5'h1f, 1'b1, 1'b0, 1'b1); idle(NTL + 15);
        step(5'h1f, 1'b0, 1'b0, 1'b0); idle(20);
        for (int s = 0; s < 60; s++) begin
            kind = $urandom_range(0, 5);
            len  = $urandom_range(10, 420);
            evt  = $urandom_range(0, len - 1);
            kp   = 5'($urandom_range(0, 30));
            st0  = 1'($urandom_range(0, 1));
            for (int c = 0; c < len; c++) begin
                case (kind)
                    1: step((c >= evt && c < evt + 30) ? kp : 5'h1f, st0 && c == 0, 1'b0, 1'b1);
                    2: step(kp, st0 && c == 0, 1'b0, 1'b1);
                    3: step(5'h1f, (st0 && c == 0) || c == evt, c == evt, 1'b1);
                    4: step(5'h1f, st0 && c == 0, 1'b0, c != evt);
                    5: begin
                        if ($urandom_range(0, 7) == 0) kp = 5'($urandom);
                        step(kp, 1'b0, 1'b0, 1'b1);
                    end
                    default: step(5'h1f, st0 && c == 0, 1'b0, 1'b1);
                endcase
            end
        end
        idle(5);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/beep_seq.md
BEEP_SEQ -- requirements
Module: beep_seq

Interface
REQ-001 SHALL have parameter TONE_UNIT, default 100_000: beep half-period in clk cycles per tone code step.
REQ-002 SHALL have parameter NOTE_LEN, default 25_000_000: sequenced note duration in clk cycles.
REQ-003 SHALL have parameter GAP_LEN, default 2_500_000: silent gap after each sequenced note, in clk cycles.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 key  input  5  active-low manual tone buttons; key[i] low requests tone code i+1.
REQ-007 start  input  1  active-high one-cycle request to play the stored melody.
REQ-008 stop  input  1  active-high request to abort melody playback.
REQ-009 beep  output  1  square-wave buzzer drive.
REQ-010 led  output  5  thermometer display of the current tone code.
REQ-011 busy  output  1  high while the melody plays, including gaps.
REQ-012 note_idx  output  3  index of the current melody note.

Function
REQ-013 SHALL pass key through a 2-flop synchronizer; all key decisions use the synchronized value, so a key change affects state on the 3rd rising edge after the change.
REQ-014 SHALL hold an internal 8-entry melody ROM of 3-bit tone codes, index 0..7 = 1,2,3,4,5,0,3,1; code 0 = rest.
REQ-015 Tone code k (1..5) SHALL give half-period H = k*TONE_UNIT; code 0 SHALL hold beep at 0.
REQ-016 Tone generator: on entering a tone state or on any tone code change, counter=0 and beep=0; each later cycle with code≠0, if counter==H-1 then counter<=0 and beep toggles, else counter increments; beep period = 2H cycles, first toggle H cycles after entry.
REQ-017 led SHALL be: code 0->00000, 1->00001, 2->00011, 3->00111, 4->01111, 5->11111, registered with the tone code.
REQ-018 SHALL implement FSM states IDLE, MANUAL, PLAY, GAP.
REQ-019 IDLE: beep=0, led=0, busy=0; any synchronized key low -> MANUAL; else start=1 -> PLAY with note_idx=0.
REQ-020 Several keys low together SHALL select the lowest key index (key[0] highest priority).
REQ-021 MANUAL: tone code = selected key; a change of selected key restarts the tone generator per REQ-016; all keys released -> IDLE on the next edge.
REQ-022 PLAY: tone code = ROM[note_idx]; busy=1; after exactly NOTE_LEN cycles -> GAP.
REQ-023 GAP: beep=0, led=0, busy=1; after exactly GAP_LEN cycles: note_idx<7 -> note_idx+1, PLAY; note_idx==7 -> IDLE, note_idx=0.
REQ-024 In PLAY or GAP, stop=1 SHALL force IDLE, note_idx=0, beep=0 on the next edge.
REQ-025 In PLAY or GAP, a synchronized key press SHALL pre-empt playback: -> MANUAL, note_idx=0, busy=0.
REQ-026 start while PLAY, GAP or MANUAL SHALL be ignored.
REQ-027 Same-cycle priority: rst_n low > stop > key > start.
REQ-028 Duration counters SHALL be 32-bit and SHALL reload to 0 on every state entry; no wrap-around within legal parameters.

Reset
REQ-029 rst_n low at a rising edge SHALL set state=IDLE, beep=0, led=0, busy=0, note_idx=0, all counters=0, synchronizer flops=1 (released), regardless of current state.
REQ-030 Reset mid-note SHALL discard playback; start is not remembered across reset.

Verification (TONE_UNIT=4, NOTE_LEN=40, GAP_LEN=8)
REQ-031 Reset release, no inputs -> beep=0, led=00000, busy=0, note_idx=0 held for 100 cycles.
REQ-032 key=11110 held -> MANUAL 3 cycles later, led=00001, beep toggles every 4 cycles; release -> IDLE, beep=0.
REQ-033 key=11010 -> key[0] wins, led=00001, H=4; then key=11011 -> tone restarts, led=00111, H=12.
REQ-034 start pulse in IDLE -> busy=1, note_idx steps 0..7 every 48 cycles, led follows 00001,00011,00111,01111,11111,00000,00111,00001; beep silent during note 5 and all gaps; IDLE after 384 cycles.
REQ-035 start, then stop during note 2 -> IDLE next edge, busy=0, note_idx=0; start and stop same cycle in IDLE -> stays IDLE.
REQ-036 During PLAY note 3, key=01111 -> MANUAL, led=11111, busy=0; rst_n low mid-note -> all outputs at reset values after that edge.
